pulse_stretcher: RTL and testbench
==================================

Name: pulse_stretcher

Overview:
Converts single-cycle event pulses, such as the outputs of the push-button edge-detect stage, into pulses of fixed width with a guaranteed low gap between them. The widened pulses are wide enough to drive LEDs, buzzers or slower downstream FSMs. Events that arrive while a pulse is still being played out are queued in a saturating pending counter, so no event is silently merged. An overflow flag reports any event that had to be dropped.

Parameters:
WIDTH_CYCLES, 4, high time of each output pulse in clock cycles; legal range 1..65535.
GAP_CYCLES, 2, minimum low time after each output pulse; legal range 1..65535. A value of 0 is illegal because consecutive pulses would merge.
PEND_MAX, 3, maximum number of queued events; legal range 1..15.

Ports:
clock  input  1  system clock; all logic is rising-edge.
reset  input  1  synchronous, active-high reset.
pulse_in  input  1  event input; every cycle it is sampled high counts as one event.
clr_overflow  input  1  clears the overflow flag.
pulse_out  output  1  stretched pulse; registered.
busy  output  1  high while in HIGH or GAP; registered.
pending  output  4  number of queued events, 0..PEND_MAX; registered.
overflow  output  1  sticky flag set when an event is dropped; registered.

Behaviour:
- Reset value of every output is 0, and the state goes to IDLE. Reset is synchronous, has priority over all inputs, and may be asserted mid-operation: the cycle after reset, pulse_out, busy, pending and overflow are all 0 and the queue is discarded.
- Internal down-counter is 16 bits wide. It is loaded with WIDTH_CYCLES-1 on entry to HIGH and with GAP_CYCLES-1 on entry to GAP.
- States:
  - IDLE: if pulse_in=1, go to HIGH.
  - HIGH: count down; when the counter reaches 0, go to GAP.
  - GAP: count down; when the counter reaches 0:
    - if pending>0 or pulse_in=1, go to HIGH;
    - otherwise go to IDLE.
- Outputs: pulse_out = (state==HIGH), busy = (state!=IDLE). Both are registered.
- Latency and timing: pulse_in sampled high at cycle k in IDLE gives:
  - pulse_out high in cycles k+1 .. k+W;
  - pulse_out low in cycles k+W+1 .. k+W+G;
  - the earliest next pulse starts at k+W+G+1.
- Queueing: pulse_in=1 while in HIGH or GAP, other than the consume case below, does the following:
  - if pending<PEND_MAX, pending increments;
  - otherwise the event is dropped and overflow is set.
- Consume at the last GAP cycle:
  - if pending>0, pending decrements and the next HIGH starts;
  - if pulse_in=1 in the same cycle, pending is net unchanged, including at PEND_MAX, and there is no overflow;
  - if pending=0 and pulse_in=1, the event is consumed directly and pending stays 0.
- Overflow:
  - overflow is sticky and is cleared only by clr_overflow or reset;
  - if clr_overflow and a new drop occur in the same cycle, set wins and overflow stays 1;
  - clr_overflow has no effect on state or pending.
- pulse_in held high for N cycles counts as N events.
- pending never wraps and never exceeds PEND_MAX.

Test Plan (W=4, G=2, PEND_MAX=3 unless noted):
1. Single pulse_in at cycle 10 -> pulse_out=1 in cycles 11-14 and 0 in 15-16; busy=1 in 11-16; busy=0 from cycle 17.
2. pulse_in at cycles 10, 12 and 13:
   - pending=1 in cycle 13 and 2 in cycles 14-16;
   - pulse_out high in 11-14, 17-20 and 23-26;
   - pending=1 in 17-22, then 0;
   - busy drops at cycle 29.
3. pulse_in high for cycles 10-14 (5 events):
   - pending saturates at 3;
   - overflow=1 from cycle 15;
   - exactly 4 output pulses at 11-14, 17-20, 23-26 and 29-32;
   - overflow still 1 at cycle 40.
4. pulse_in at cycle 10 and again at cycle 16 (last GAP cycle) -> second pulse high 17-20; pending stays 0 throughout.
5. Pulses at 10, 11 and 12, then reset=1 at cycle 13 -> cycle 14 has pulse_out=0, busy=0, pending=0; a new pulse_in at 15 gives pulse_out high in 16-19.
6. Overflow=1, then clr_overflow=1 at the same cycle as a dropped event -> overflow remains 1. clr_overflow alone at a later cycle -> overflow=0 the next cycle, with pulse_out timing unaffected.
7. Parameter sweep W=1, G=1 with back-to-back pulse_in every cycle -> pulse_out toggles 1,0,1,0 and never has two consecutive highs.

Source files
------------

// File: rtl/pulse_stretcher.sv
// Widens single-cycle events into fixed-width pulses separated by a minimum low gap.
// Events arriving mid-pulse are queued in a saturating counter; drops raise a sticky overflow flag.
module pulse_stretcher #(
    parameter int WIDTH_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int PEND_MAX     = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pulse_in,
    input  logic       clr_overflow,
    output logic       pulse_out,
    output logic       busy,
    output logic [3:0] pending,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [15:0] W_LOAD   = 16'(WIDTH_CYCLES - 1);
    localparam logic [15:0] G_LOAD   = 16'(GAP_CYCLES - 1);
    localparam logic [3:0]  PEND_TOP = 4'(PEND_MAX);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  pend_q, pend_d;
    logic        ovf_q, ovf_d;
    logic        pulse_out_q;
    logic        busy_q;
    logic        last_gap;
    logic        drop;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        drop     = 1'b0;
        last_gap = (state_q == GAP) && (cnt_q == 16'd0);

        case (state_q)
            IDLE: begin
                if (pulse_in) begin
                    state_d = HIGH;
                    cnt_d   = W_LOAD;
                end
            end
            HIGH: begin
                if (cnt_q == 16'd0) begin
                    state_d = GAP;
                    cnt_d   = G_LOAD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            GAP: begin
                if (cnt_q == 16'd0) begin
                    if ((pend_q != 4'd0) || pulse_in) begin
                        state_d = HIGH;
                        cnt_d   = W_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase

        // On the last gap cycle a new event replaces the queued one it would consume,
        // so the count only drops when the queue feeds the next pulse on its own.
        if (last_gap) begin
            if ((pend_q != 4'd0) && !pulse_in) begin
                pend_d = pend_q - 4'd1;
            end
        end else if ((state_q != IDLE) && pulse_in) begin
            if (pend_q < PEND_TOP) begin
                pend_d = pend_q + 4'd1;
            end else begin
                drop = 1'b1;
            end
        end

        ovf_d = drop | (ovf_q & ~clr_overflow);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            pend_q      <= 4'd0;
            ovf_q       <= 1'b0;
            pulse_out_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            pulse_out_q <= (state_d == HIGH);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign pulse_out = pulse_out_q;
    assign busy      = busy_q;
    assign pending   = pend_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: expectations are queued per cycle and checked by a monitor.
// dut_a uses the default parameters, dut_b uses W=1, G=1.
module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pin_a = 1'b0;
    logic       pin_b = 1'b0;
    logic       clr_a = 1'b0;
    logic       po_a, busy_a, ovf_a;
    logic [3:0] pend_a;
    logic       po_b, busy_b, ovf_b;
    logic [3:0] pend_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int base  = 0;

    logic [63:0] pin_m, pinb_m, clr_m, rst_m;

    typedef struct {
        int    at;
        int    kind;
        int    want;
        string nm;
    } exp_t;

    exp_t sb[$];

    pulse_stretcher #(.WIDTH_CYCLES(4), .GAP_CYCLES(2), .PEND_MAX(3)) dut_a (
        .clock(clk), .reset(reset), .pulse_in(pin_a), .clr_overflow(clr_a),
        .pulse_out(po_a), .busy(busy_a), .pending(pend_a), .overflow(ovf_a)
    );

    pulse_stretcher #(.WIDTH_CYCLES(1), .GAP_CYCLES(1), .PEND_MAX(3)) dut_b (
        .clock(clk), .reset(reset), .pulse_in(pin_b), .clr_overflow(1'b0),
        .pulse_out(po_b), .busy(busy_b), .pending(pend_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int actual(int kind);
        case (kind)
            0:       return int'(po_a);
            1:       return int'(busy_a);
            2:       return int'(pend_a);
            3:       return int'(ovf_a);
            default: return int'(po_b);
        endcase
    endfunction

    // Monitor: consume every expectation whose cycle has arrived.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at < cyc) begin
                total++;
                bad++;
                $display("FAIL %s stale at=%0d now=%0d", sb[i].nm, sb[i].at, cyc);
                sb.delete(i);
            end else if (sb[i].at == cyc) begin
                total++;
                if (actual(sb[i].kind) != sb[i].want) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%0d want=%0d", sb[i].nm,
                             cyc - base, actual(sb[i].kind), sb[i].want);
                end
                sb.delete(i);
            end
        end
    end

    function automatic logic [63:0] bits(int lo, int hi);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic expect_range(int lo, int hi, int kind, int want, string nm);
        for (int r = lo; r <= hi; r++) begin
            exp_t e;
            e.at = base + r; e.kind = kind; e.want = want; e.nm = nm;
            sb.push_back(e);
        end
    endtask

    task automatic begin_test(string name);
        pin_m = '0; pinb_m = '0; clr_m = '0; rst_m = '0;
        reset = 1'b1; pin_a = 1'b0; pin_b = 1'b0; clr_a = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        base = cyc;
        expect_range(0, 0, 0, 0, {name, "_rst_po"});
        expect_range(0, 0, 1, 0, {name, "_rst_busy"});
        expect_range(0, 0, 2, 0, {name, "_rst_pend"});
        expect_range(0, 0, 3, 0, {name, "_rst_ovf"});
        expect_range(0, 0, 4, 0, {name, "_rst_po_b"});
    endtask

    task automatic drive(int len);
        for (int r = 0; r < len; r++) begin
            pin_a = pin_m[r];
            pin_b = pinb_m[r];
            clr_a = clr_m[r];
            reset = rst_m[r];
            @(posedge clk); #1;
        end
        pin_a = 1'b0; pin_b = 1'b0; clr_a = 1'b0; reset = 1'b0;
        for (int w = 0; w < 5 && sb.size() != 0; w++) @(posedge clk);
        if (sb.size() != 0) begin
            $display("FAIL drain left=%0d want=0", sb.size());
            total++;
            bad++;
            sb.delete();
        end
    endtask

    initial begin
        // single event
        begin_test("t1");
        pin_m[10] = 1'b1;
        expect_range(1, 10, 0, 0, "t1_po");
        expect_range(11, 14, 0, 1, "t1_po");
        expect_range(15, 20, 0, 0, "t1_po");
        expect_range(1, 10, 1, 0, "t1_busy");
        expect_range(11, 16, 1, 1, "t1_busy");
        expect_range(17, 20, 1, 0, "t1_busy");
        expect_range(1, 20, 2, 0, "t1_pend");
        drive(22);

        // queued events
        begin_test("t2");
        pin_m[10] = 1'b1; pin_m[12] = 1'b1; pin_m[13] = 1'b1;
        expect_range(11, 14, 0, 1, "t2_po");
        expect_range(15, 16, 0, 0, "t2_po");
        expect_range(17, 20, 0, 1, "t2_po");
        expect_range(21, 22, 0, 0, "t2_po");
        expect_range(23, 26, 0, 1, "t2_po");
        expect_range(27, 32, 0, 0, "t2_po");
        expect_range(1, 12, 2, 0, "t2_pend");
        expect_range(13, 13, 2, 1, "t2_pend");
        expect_range(14, 16, 2, 2, "t2_pend");
        expect_range(17, 22, 2, 1, "t2_pend");
        expect_range(23, 32, 2, 0, "t2_pend");
        expect_range(11, 28, 1, 1, "t2_busy");
        expect_range(29, 32, 1, 0, "t2_busy");
        drive(34);

        // saturation and overflow
        begin_test("t3");
        pin_m = bits(10, 14);
        expect_range(11, 14, 0, 1, "t3_po");
        expect_range(15, 16, 0, 0, "t3_po");
        expect_range(17, 20, 0, 1, "t3_po");
        expect_range(21, 22, 0, 0, "t3_po");
        expect_range(23, 26, 0, 1, "t3_po");
        expect_range(27, 28, 0, 0, "t3_po");
        expect_range(29, 32, 0, 1, "t3_po");
        expect_range(33, 40, 0, 0, "t3_po");
        expect_range(12, 12, 2, 1, "t3_pend");
        expect_range(13, 13, 2, 2, "t3_pend");
        expect_range(14, 16, 2, 3, "t3_pend");
        expect_range(17, 22, 2, 2, "t3_pend");
        expect_range(23, 28, 2, 1, "t3_pend");
        expect_range(29, 40, 2, 0, "t3_pend");
        expect_range(1, 14, 3, 0, "t3_ovf");
        expect_range(15, 40, 3, 1, "t3_ovf");
        expect_range(35, 40, 1, 0, "t3_busy");
        drive(42);

        // event on the last gap cycle is consumed directly
        begin_test("t4");
        pin_m[10] = 1'b1; pin_m[16] = 1'b1;
        expect_range(11, 14, 0, 1, "t4_po");
        expect_range(15, 16, 0, 0, "t4_po");
        expect_range(17, 20, 0, 1, "t4_po");
        expect_range(21, 24, 0, 0, "t4_po");
        expect_range(1, 24, 2, 0, "t4_pend");
        expect_range(3, 24, 3, 0, "t4_ovf");
        expect_range(11, 22, 1, 1, "t4_busy");
        expect_range(23, 24, 1, 0, "t4_busy");
        drive(26);

        // mid-operation reset
        begin_test("t5");
        pin_m[10] = 1'b1; pin_m[11] = 1'b1; pin_m[12] = 1'b1; pin_m[15] = 1'b1;
        rst_m[13] = 1'b1;
        expect_range(11, 13, 0, 1, "t5_po");
        expect_range(14, 15, 0, 0, "t5_po");
        expect_range(16, 19, 0, 1, "t5_po");
        expect_range(20, 22, 0, 0, "t5_po");
        expect_range(12, 12, 2, 1, "t5_pend");
        expect_range(13, 13, 2, 2, "t5_pend");
        expect_range(14, 22, 2, 0, "t5_pend");
        expect_range(14, 15, 1, 0, "t5_busy");
        expect_range(16, 21, 1, 1, "t5_busy");
        expect_range(22, 22, 1, 0, "t5_busy");
        drive(24);

        // clear versus simultaneous drop, then clear alone
        begin_test("t6");
        pin_m = bits(10, 15);
        clr_m[15] = 1'b1; clr_m[20] = 1'b1;
        expect_range(15, 20, 3, 1, "t6_ovf");
        expect_range(21, 40, 3, 0, "t6_ovf");
        expect_range(14, 16, 2, 3, "t6_pend");
        expect_range(17, 22, 2, 2, "t6_pend");
        expect_range(23, 28, 2, 1, "t6_pend");
        expect_range(11, 14, 0, 1, "t6_po");
        expect_range(15, 16, 0, 0, "t6_po");
        expect_range(17, 20, 0, 1, "t6_po");
        expect_range(21, 22, 0, 0, "t6_po");
        expect_range(23, 26, 0, 1, "t6_po");
        expect_range(27, 28, 0, 0, "t6_po");
        expect_range(29, 32, 0, 1, "t6_po");
        expect_range(33, 40, 0, 0, "t6_po");
        drive(42);

        // W=1, G=1 with events every cycle: output alternates
        begin_test("t7");
        pinb_m = bits(10, 30);
        for (int r = 10; r <= 42; r++)
            expect_range(r, r, 4, ((r % 2) == 1 && r <= 37) ? 1 : 0, "t7_po_b");
        expect_range(1, 42, 0, 0, "t7_po_a");
        drive(44);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d want=finish", cyc);
        $fatal(1);
    end

endmodule
